// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and op-class helpers for the multiply/divide engine
package muldiv_pkg;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_MULHU = 3'd1;
    localparam logic [2:0] MD_MULH  = 3'd2;
    localparam logic [2:0] MD_RSV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_REMU  = 3'd5;
    localparam logic [2:0] MD_DIV   = 3'd6;
    localparam logic [2:0] MD_REM   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return op == MD_MULH || op == MD_DIV || op == MD_REM;
    endfunction

    function automatic logic want_high(input logic [2:0] op);
        return op == MD_MULH || op == MD_MULHU;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: turns the unsigned accumulator into the final result, carry and zero flags
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] mag,
    input  logic               neg,
    input  logic               dz,
    input  logic [2:0]         op,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero
);

    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   sel;
    logic [WIDTH-1:0]   dq;

    // Products negate across the full double width; divides negate only the selected half.
    always_comb begin
        p      = neg ? -mag : mag;
        sel    = op[0] ? mag[2*WIDTH-1:WIDTH] : mag[WIDTH-1:0];
        dq     = neg ? -sel : sel;
        result = op == MD_RSV ? '0 : is_div(op) ? dq : want_high(op) ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
        carry  = is_div(op) ? dz : op == MD_MUL && |p[2*WIDTH-1:WIDTH];
        zero   = result == '0;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiply/divide engine with start/busy/done handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;
    logic               neg_r;
    logic               dz_r;

    logic               sa, sb, dz_in, neg_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_r, div_d;
    logic               borrow;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_carry, fix_zero;

    // A divide-by-zero quotient stays all ones, so its sign is never applied.
    always_comb begin
        sa       = is_signed(op) & data0[WIDTH-1];
        sb       = is_signed(op) & data1[WIDTH-1];
        a_mag    = sa ? -data0 : data0;
        b_mag    = sb ? -data1 : data1;
        dz_in    = data1 == '0;
        neg_in   = op == MD_MULH ? sa ^ sb : op == MD_DIV ? (sa ^ sb) & ~dz_in : op == MD_REM ? sa : 1'b0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_r[0] ? {1'b0, a_r} : '0);
        div_r    = {acc[2*WIDTH-1:WIDTH], a_r[WIDTH-1]};
        div_d    = div_r - {1'b0, b_r};
        borrow   = div_r < {1'b0, b_r};
        acc_next = is_div(op_r) ? {borrow ? div_r[WIDTH-1:0] : div_d[WIDTH-1:0], acc[WIDTH-2:0], ~borrow}
                                : {mul_sum, acc[WIDTH-1:1]};
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .mag    (acc),
        .neg    (neg_r),
        .dz     (dz_r),
        .op     (op_r),
        .result (fix_result),
        .carry  (fix_carry),
        .zero   (fix_zero)
    );

    assign busy = state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            neg_r  <= 1'b0;
            dz_r   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && kill) begin
                state <= S_IDLE;
            end else if (state == S_IDLE) begin
                if (start) begin
                    op_r  <= op;
                    a_r   <= a_mag;
                    b_r   <= b_mag;
                    acc   <= '0;
                    neg_r <= neg_in;
                    dz_r  <= dz_in;
                    cnt   <= CNT_W'(WIDTH);
                    state <= S_RUN;
                end
            end else if (state == S_RUN) begin
                acc <= acc_next;
                if (is_div(op_r)) a_r <= a_r << 1;
                else b_r <= b_r >> 1;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state <= S_FIX;
            end else begin
                result <= fix_result;
                carry  <= fix_carry;
                zero   <= fix_zero;
                done   <= 1'b1;
                state  <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         kill = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         busy, done, carry, zero;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .data0  (data0),
        .data1  (data1),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } vec_t;

    // Returns {carry, result} computed with plain 64-bit arithmetic.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb;
        logic [63:0]  p;
        logic [W-1:0] r;
        logic         c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {32'b0, a} * {32'b0, b};
        r  = '0;
        c  = 1'b0;
        case (o)
            MD_MUL:   begin r = p[31:0]; c = p[63:32] != 32'd0; end
            MD_MULHU: r = p[63:32];
            MD_MULH:  begin p = 64'(sa * sb); r = p[63:32]; end
            MD_DIVU:  if (b == 0) begin r = '1; c = 1'b1; end else r = a / b;
            MD_REMU:  if (b == 0) begin r = a; c = 1'b1; end else r = a % b;
            MD_DIV:   if (b == 0) begin r = '1; c = 1'b1; end else begin p = 64'(sa / sb); r = p[31:0]; end
            MD_REM:   if (b == 0) begin r = a; c = 1'b1; end else begin p = 64'(sa % sb); r = p[31:0]; end
            default:  ;
        endcase
        return {c, r};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        data0 = a;
        data1 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, carry, zero} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b result=%h carry=%b zero=%b, want all 0", busy, done, result, carry, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        int lat, bc;
        issue(MD_MUL, 32'd7, 32'd6);
        wait_done(lat, bc);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL mul_latency: got %0d edges, want 33", lat);
        end
        checks++;
        if (bc !== 33) begin
            errors++;
            $display("FAIL mul_busy_cycles: got %0d, want 33", bc);
        end
        checks++;
        if ({result, carry, zero} !== {32'd42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_7x6: got %h c=%b z=%b, want 0000002a c=0 z=0", result, carry, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, result} !== {1'b0, 32'd42}) begin
            errors++;
            $display("FAIL done_pulse: got done=%b result=%h, want done=0 result=0000002a", done, result);
        end
    endtask

    task automatic test_directed();
        vec_t tv [13];
        int   lat, bc;
        tv = '{
            '{MD_MULH,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0},
            '{MD_MULHU, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0, 1'b0},
            '{MD_MUL,   32'h8000_0000, 32'd2,         32'd0,         1'b1, 1'b1},
            '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0},
            '{MD_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0},
            '{MD_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 1'b0},
            '{MD_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 1'b0},
            '{MD_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0},
            '{MD_REM,   32'd5,         32'd0,         32'd5,         1'b1, 1'b0},
            '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0},
            '{MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1},
            '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0},
            '{MD_RSV,   32'd5,         32'd6,         32'd0,         1'b0, 1'b1}
        };
        for (int i = 0; i < 13; i++) begin
            issue(tv[i].op, tv[i].a, tv[i].b);
            wait_done(lat, bc);
            checks++;
            if (lat !== 33 || {result, carry, zero} !== {tv[i].r, tv[i].c, tv[i].z}) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: got %h c=%b z=%b lat=%0d, want %h c=%b z=%b lat=33",
                         i, tv[i].op, tv[i].a, tv[i].b, result, carry, zero, lat, tv[i].r, tv[i].c, tv[i].z);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] a, b;
        logic [W:0]   exp;
        int           lat, bc;
        for (int i = 0; i < 60; i++) begin
            o   = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = model(o, a, b);
            issue(o, a, b);
            wait_done(lat, bc);
            checks++;
            if (lat !== 33 || {carry, result} !== exp || zero !== (exp[W-1:0] == '0)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h c=%b z=%b lat=%0d, want %h c=%b z=%b lat=33",
                         i, o, a, b, result, carry, zero, lat, exp[W-1:0], exp[W], exp[W-1:0] == '0);
            end
        end
    endtask

    task automatic test_kill();
        int lat, bc;
        bit seen;
        issue(MD_MUL, 32'd7, 32'd6);
        wait_done(lat, bc);
        checks++;
        if (result !== 32'd42) begin
            errors++;
            $display("FAIL kill_setup: got %h, want 0000002a", result);
        end
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: got busy=%b, want 0", busy);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if ({seen, result, carry, zero} !== {1'b0, 32'd42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL kill_hold: got done_seen=%b result=%h c=%b z=%b, want 0 0000002a 0 0", seen, result, carry, zero);
        end
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        kill  = 1'b1;
        start = 1'b1;
        op    = MD_MUL;
        data0 = 32'd3;
        data1 = 32'd3;
        @(posedge clk);
        #1;
        kill  = 1'b0;
        start = 1'b0;
        seen  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_over_start: got busy=%b, want 0", busy);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if ({seen, result} !== {1'b0, 32'd42}) begin
            errors++;
            $display("FAIL kill_over_start_hold: got done_seen=%b result=%h, want 0 0000002a", seen, result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done(lat, bc);
        checks++;
        if (result !== 32'd14) begin
            errors++;
            $display("FAIL b2b_first: got %h, want 0000000e", result);
        end
        start = 1'b1;
        op    = MD_REMU;
        data0 = 32'd100;
        data1 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = MD_MUL;
        data0 = 32'd0;
        data1 = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (lat !== 27 || {result, carry, zero} !== {32'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_ignore_busy_start: got %h c=%b z=%b lat=%0d, want 00000002 c=0 z=0 lat=27", result, carry, zero, lat);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_done(lat, bc);
        issue(MD_MUL, 32'd7, 32'd6);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carry, zero} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b result=%h carry=%b zero=%b, want all 0", busy, done, result, carry, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(MD_MUL, 32'd3, 32'd3);
        wait_done(lat, bc);
        checks++;
        if (lat !== 33 || {result, carry, zero} !== {32'd9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_mul: got %h c=%b z=%b lat=%0d, want 00000009 c=0 z=0 lat=33", result, carry, zero, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_random();
        test_kill();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
